// File: rtl/fixed_subtractor_pipe.sv
// Streaming fixed-point subtractor: result = u - v in u's format, with v aligned to
// u's binary point, two-stage valid/ready pipeline and optional saturation.
module fixed_subtractor_pipe #(
    parameter int WIDTH1   = 16,
    parameter int FRAC1    = 8,
    parameter int WIDTH2   = 16,
    parameter int FRAC2    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [WIDTH1-1:0] u_in,
    input  logic [WIDTH2-1:0] v_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH1-1:0] result_out,
    output logic              ovf_out,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int D  = FRAC2 - FRAC1;
    localparam int AW = (D < 0) ? WIDTH2 - D : WIDTH2;
    localparam int DW = ((WIDTH1 > AW) ? WIDTH1 : AW) + 1;

    localparam logic signed [DW-1:0] MAX_V = {{(DW-WIDTH1+1){1'b0}}, {(WIDTH1-1){1'b1}}};
    localparam logic signed [DW-1:0] MIN_V = {{(DW-WIDTH1+1){1'b1}}, {(WIDTH1-1){1'b0}}};

    // Exact subtraction at DW bits, then range check and clamp/wrap; returns {ovf, result}.
    function automatic logic [WIDTH1:0] sub_sat(input logic signed [WIDTH1-1:0] a,
                                                input logic signed [AW-1:0]     b);
        logic signed [DW-1:0] diff;
        logic                 ovf;
        logic [WIDTH1-1:0]    res;
        diff = {{(DW-WIDTH1){a[WIDTH1-1]}}, a} - {{(DW-AW){b[AW-1]}}, b};
        ovf  = (diff > MAX_V) || (diff < MIN_V);
        res  = diff[WIDTH1-1:0];
        if (SATURATE && ovf) begin
            res = diff[DW-1] ? {1'b1, {(WIDTH1-1){1'b0}}} : {1'b0, {(WIDTH1-1){1'b1}}};
        end
        return {ovf, res};
    endfunction

    logic signed [AW-1:0] v_al;

    generate
        if (D > 0) begin : g_align_right
            assign v_al = $signed(v_in) >>> D;
        end else if (D < 0) begin : g_align_left
            assign v_al = {v_in, {(-D){1'b0}}};
        end else begin : g_align_none
            assign v_al = v_in;
        end
    endgenerate

    logic                     vld_p1_q, vld_p1_d;
    logic signed [WIDTH1-1:0] u_p1_q, u_p1_d;
    logic signed [AW-1:0]     v_p1_q, v_p1_d;
    logic                     vld_p2_q, vld_p2_d;
    logic [WIDTH1-1:0]        res_p2_q, res_p2_d;
    logic                     ovf_p2_q, ovf_p2_d;
    logic                     s1_adv, s2_adv;

    always_comb begin
        s2_adv   = !vld_p2_q || out_ready;
        s1_adv   = !vld_p1_q || s2_adv;
        vld_p1_d = vld_p1_q;
        u_p1_d   = u_p1_q;
        v_p1_d   = v_p1_q;
        vld_p2_d = vld_p2_q;
        res_p2_d = res_p2_q;
        ovf_p2_d = ovf_p2_q;
        // Stage 1: capture aligned operands on accept
        if (s1_adv) begin
            vld_p1_d = in_valid;
            if (in_valid) begin
                u_p1_d = u_in;
                v_p1_d = v_al;
            end
        end
        // Stage 2: subtract and clamp; data only moves when stage 1 holds a beat
        if (s2_adv) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                {ovf_p2_d, res_p2_d} = sub_sat(u_p1_q, v_p1_q);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            res_p2_q <= '0;
            ovf_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            res_p2_q <= res_p2_d;
            ovf_p2_q <= ovf_p2_d;
        end
    end

    always_ff @(posedge clk_in) begin
        u_p1_q <= u_p1_d;
        v_p1_q <= v_p1_d;
    end

    assign in_ready   = s1_adv;
    assign result_out = res_p2_q;
    assign ovf_out    = ovf_p2_q;
    assign out_valid  = vld_p2_q;

endmodule

// File: tb/tb_fixed_subtractor_pipe.sv
// Bench for fixed_subtractor_pipe: three parameterisations driven in lockstep, checked by
// a vector table, hand-written stall/reset sequences and a queue-based reference model.
module tb_fixed_subtractor_pipe;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [15:0] u_in = '0, v_in = '0;
    logic        in_valid = 1'b0, out_ready = 1'b1;

    logic        rdy0, rdy_w, rdy_a;
    logic [15:0] res0, res_w, res_a;
    logic        ovf0, ovf_w, ovf_a;
    logic        vld0, vld_w, vld_a;

    int n_chk = 0;
    int n_fail = 0;
    int n_out = 0;

    always #5 clk = ~clk;

    fixed_subtractor_pipe #(.WIDTH1(16), .FRAC1(8), .WIDTH2(16), .FRAC2(8), .SATURATE(1'b1)) dut0 (
        .clk_in(clk), .rst_in(rst_in), .u_in(u_in), .v_in(v_in), .in_valid(in_valid),
        .in_ready(rdy0), .result_out(res0), .ovf_out(ovf0), .out_valid(vld0), .out_ready(out_ready));

    fixed_subtractor_pipe #(.WIDTH1(16), .FRAC1(8), .WIDTH2(16), .FRAC2(8), .SATURATE(1'b0)) dut_w (
        .clk_in(clk), .rst_in(rst_in), .u_in(u_in), .v_in(v_in), .in_valid(in_valid),
        .in_ready(rdy_w), .result_out(res_w), .ovf_out(ovf_w), .out_valid(vld_w), .out_ready(out_ready));

    fixed_subtractor_pipe #(.WIDTH1(16), .FRAC1(8), .WIDTH2(16), .FRAC2(12), .SATURATE(1'b1)) dut_a (
        .clk_in(clk), .rst_in(rst_in), .u_in(u_in), .v_in(v_in), .in_valid(in_valid),
        .in_ready(rdy_a), .result_out(res_a), .ovf_out(ovf_a), .out_valid(vld_a), .out_ready(out_ready));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: scale v to u's LSB with floor, subtract as plain integers, then range-check.
    function automatic void model(input logic [15:0] u, input logic [15:0] v, input int frac2,
                                  input bit sat, output logic [15:0] r, output logic o);
        longint ui, vi, vs, d, p;
        int sh;
        ui = longint'($signed(u));
        vi = longint'($signed(v));
        sh = frac2 - 8;
        if (sh > 0) begin
            p  = longint'(1) << sh;
            vs = vi / p;
            if (vs * p > vi) vs = vs - 1;
        end else if (sh < 0) begin
            vs = vi * (longint'(1) << (-sh));
        end else begin
            vs = vi;
        end
        d = ui - vs;
        o = (d > 32767) || (d < -32768);
        if (o && sat) r = (d > 0) ? 16'h7FFF : 16'h8000;
        else          r = d[15:0];
    endfunction

    typedef struct {
        logic [15:0] u;
        logic [15:0] v;
    } beat_t;

    beat_t q[$];
    logic        hold_v = 1'b0;
    logic [15:0] hold_r = '0;
    logic        hold_o = 1'b0;

    always @(negedge clk) begin
        beat_t       e;
        logic [15:0] er;
        logic        eo;
        if (rst_in) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            if (vld0 && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", {16'h0, res0}, 32'hDEAD);
                end else begin
                    e = q.pop_front();
                    model(e.u, e.v, 8, 1'b1, er, eo);
                    chk("sb_res_sat", res0, er);
                    chk("sb_ovf_sat", ovf0, eo);
                    model(e.u, e.v, 8, 1'b0, er, eo);
                    chk("sb_vld_wrap", vld_w, 1);
                    chk("sb_res_wrap", res_w, er);
                    chk("sb_ovf_wrap", ovf_w, eo);
                    model(e.u, e.v, 12, 1'b1, er, eo);
                    chk("sb_vld_align", vld_a, 1);
                    chk("sb_res_align", res_a, er);
                    chk("sb_ovf_align", ovf_a, eo);
                    n_out++;
                end
            end
            if (hold_v) begin
                chk("hold_valid", vld0, 1);
                chk("hold_res", res0, hold_r);
                chk("hold_ovf", ovf0, hold_o);
            end
            hold_v = vld0 && !out_ready;
            hold_r = res0;
            hold_o = ovf0;
            if (in_valid && rdy0) begin
                chk("rdy_lockstep_w", rdy_w, 1);
                chk("rdy_lockstep_a", rdy_a, 1);
                q.push_back('{u: u_in, v: v_in});
            end
        end
    end

    typedef struct {
        logic [15:0] u;
        logic [15:0] v;
        int          dut;
        logic [15:0] r;
        logic        o;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [16:0] pick(input int dut);
        case (dut)
            1:       return {ovf_w, res_w};
            2:       return {ovf_a, res_a};
            default: return {ovf0, res0};
        endcase
    endfunction

    task automatic run_vec(input int i);
        int          lat;
        logic [16:0] got;
        @(posedge clk); #1;
        u_in = tbl[i].u; v_in = tbl[i].v; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("vec%0d_in_ready", i), rdy0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!vld0 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("vec%0d_latency", i), lat, 2);
        got = pick(tbl[i].dut);
        chk($sformatf("vec%0d_res", i), got[15:0], tbl[i].r);
        chk($sformatf("vec%0d_ovf", i), got[16], tbl[i].o);
    endtask

    task automatic drain();
        int c;
        in_valid = 1'b0;
        out_ready = 1'b1;
        c = 0;
        while ((q.size() != 0 || vld0) && c < 30) begin
            @(negedge clk);
            c++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        int   sent, c, base, accepted;
        logic acc, saw;

        tbl[0] = '{16'h0300, 16'h0180, 0, 16'h0180, 1'b0};
        tbl[1] = '{16'h7F00, 16'h8000, 0, 16'h7FFF, 1'b1};
        tbl[2] = '{16'h7F00, 16'h8000, 1, 16'hFF00, 1'b1};
        tbl[3] = '{16'h8000, 16'h0100, 0, 16'h8000, 1'b1};
        tbl[4] = '{16'h8000, 16'hFFFF, 0, 16'h8001, 1'b0};
        tbl[5] = '{16'h8000, 16'h0001, 0, 16'h8000, 1'b1};
        tbl[6] = '{16'h8000, 16'h0001, 1, 16'h7FFF, 1'b1};
        tbl[7] = '{16'h0100, 16'h0800, 2, 16'h0080, 1'b0};
        tbl[8] = '{16'h0100, 16'hFFFF, 2, 16'h0101, 1'b0};
        tbl[9] = '{16'h0000, 16'h0000, 0, 16'h0000, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst_in = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", vld0, 0);
        chk("reset_result", res0, 0);
        chk("reset_ovf", ovf0, 0);
        chk("reset_in_ready", rdy0, 1);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Back-to-back stream of 6 with a 3-cycle output stall
        base = n_out; sent = 0; saw = 1'b0; c = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; u_in = 16'($urandom); v_in = 16'($urandom); out_ready = 1'b1;
        while (sent < 6 && c < 50) begin
            @(negedge clk);
            if (in_valid && !rdy0) saw = 1'b1;
            acc = in_valid && rdy0;
            if (acc) sent++;
            @(posedge clk); #1;
            c++;
            out_ready = !(c >= 3 && c <= 5);
            if (acc) begin
                if (sent < 6) begin
                    u_in = 16'($urandom); v_in = 16'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        c = 0;
        while (n_out - base < 6 && c < 20) begin
            out_ready = 1'b1;
            @(negedge clk);
            c++;
        end
        chk("stall_in_ready_fell", saw, 1);
        chk("stall_delivered", n_out - base, 6);
        drain();

        // Reset with both stages full: nothing in flight may surface afterwards
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; u_in = 16'h1234; v_in = 16'h0042;
        sent = 0; c = 0;
        while (sent < 2 && c < 10) begin
            @(negedge clk);
            acc = in_valid && rdy0;
            if (acc) sent++;
            @(posedge clk); #1;
            c++;
            if (acc) u_in = u_in + 16'h0100;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready_low", rdy0, 0);
        chk("full_out_valid", vld0, 1);
        @(posedge clk); #1;
        rst_in = 1'b1;
        @(posedge clk); #1;
        rst_in = 1'b0;
        base = n_out;
        @(negedge clk);
        chk("midrst_out_valid", vld0, 0);
        chk("midrst_result", res0, 0);
        chk("midrst_in_ready", rdy0, 1);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_stale", n_out - base, 0);
        chk("midrst_still_idle", vld0, 0);

        // Randomized flow against the reference model
        accepted = 0; c = 0;
        @(posedge clk); #1;
        in_valid = ($urandom % 4) != 0; out_ready = ($urandom % 4) != 0;
        u_in = 16'($urandom); v_in = 16'($urandom);
        while (accepted < 300 && c < 5000) begin
            @(negedge clk);
            acc = in_valid && rdy0;
            if (acc) accepted++;
            @(posedge clk); #1;
            c++;
            out_ready = ($urandom % 4) != 0;
            if (acc || !in_valid) begin
                in_valid = ($urandom % 4) != 0;
                case ($urandom % 6)
                    0:       u_in = 16'h8000;
                    1:       u_in = 16'h7FFF;
                    default: u_in = 16'($urandom);
                endcase
                case ($urandom % 6)
                    0:       v_in = 16'hFFFF;
                    1:       v_in = 16'h0001;
                    2:       v_in = 16'h8000;
                    default: v_in = 16'($urandom);
                endcase
            end
        end
        chk("random_accepted", accepted, 300);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
